// File: rtl/bnn_layer_master.sv
// Avalon-MM master that evaluates one binarised fully-connected layer held in SDRAM.
// Optional macro ACC_SAT_EN: saturate accumulator and bias sums instead of two's-complement wrap.
module bnn_layer_master #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 16,
    parameter int MAX_IN   = 784,
    parameter int MAX_OUT  = 200,
    parameter int ADDR_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           in_count,
    input  logic [15:0]           out_count,
    input  logic [ADDR_W-1:0]     act_base,
    input  logic [ADDR_W-1:0]     wgt_base,
    input  logic [ADDR_W-1:0]     bias_base,
    input  logic [ADDR_W-1:0]     res_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state,
    output logic [ADDR_W-1:0]     address,
    output logic                  read_n,
    output logic                  write_n,
    output logic                  chipselect,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,
    input  logic                  readdatavalid
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_ACT = 3'd1,
        S_WEIGHTS  = 3'd2,
        S_BIAS     = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int AIW = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
    localparam int OIW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    state_t              state_reg, state_next;
    logic [15:0]         in_cnt_reg, out_cnt_reg;
    logic [31:0]         wgt_total_reg;
    logic [ADDR_W-1:0]   wgt_base_reg, bias_base_reg, res_base_reg, addr_reg;
    logic [31:0]         issued_reg, received_reg;
    logic                read_n_reg, write_n_reg, err_reg;
    logic [DATA_W-1:0]   writedata_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [15:0]         i_reg, n_reg, k_reg;

    logic                act_mem [MAX_IN];
    logic [ACC_W-1:0]    sum_mem [MAX_OUT];
    logic                res_mem [MAX_OUT];

    logic                in_read, accept, rvalid, phase_end, req_next;
    logic                wr_accept, wr_last, cfg_bad, i_last;
    logic [31:0]         total, issued_next, received_next;
    logic [ACC_W-1:0]    wt_ext, acc_sum, bias_sum;
    logic [15:0]         k_inc;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
`ifdef ACC_SAT_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The two top bits disagree only on signed overflow; the guard bit gives the true sign.
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign cfg_bad = (in_count == 16'd0) || (32'(in_count) > 32'(MAX_IN)) ||
                     (out_count == 16'd0) || (32'(out_count) > 32'(MAX_OUT));

    assign in_read       = (state_reg == S_LOAD_ACT) || (state_reg == S_WEIGHTS) ||
                           (state_reg == S_BIAS);
    assign accept        = in_read && !read_n_reg && !waitrequest;
    assign rvalid        = in_read && readdatavalid;
    assign issued_next   = issued_reg + 32'(accept);
    assign received_next = received_reg + 32'(rvalid);
    assign phase_end     = in_read && (received_next == total);
    assign req_next      = (issued_next < total) &&
                           ((issued_next - received_next) < 32'(MAX_PEND));

    assign wr_accept = (state_reg == S_WRITE) && !write_n_reg && !waitrequest;
    assign wr_last   = wr_accept && (k_reg == out_cnt_reg - 16'd1);
    assign k_inc     = k_reg + 16'd1;

    assign wt_ext   = ACC_W'($signed(readdata));
    assign acc_sum  = act_mem[i_reg[AIW-1:0]] ? acc_add(acc_reg, wt_ext) : acc_reg;
    assign i_last   = (i_reg == in_cnt_reg - 16'd1);
    assign bias_sum = acc_add(sum_mem[received_reg[OIW-1:0]], wt_ext);

    always_comb begin
        total = 32'd0;
        case (state_reg)
            S_LOAD_ACT: total = 32'(in_cnt_reg);
            S_WEIGHTS:  total = wgt_total_reg;
            S_BIAS:     total = 32'(out_cnt_reg);
            default:    total = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (start) state_next = cfg_bad ? S_DONE : S_LOAD_ACT;
            S_LOAD_ACT: if (phase_end) state_next = S_WEIGHTS;
            S_WEIGHTS:  if (phase_end) state_next = S_BIAS;
            S_BIAS:     if (phase_end) state_next = S_WRITE;
            S_WRITE:    if (wr_last) state_next = S_DONE;
            S_DONE:     if (!start) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            wgt_total_reg <= '0;
            wgt_base_reg  <= '0;
            bias_base_reg <= '0;
            res_base_reg  <= '0;
            addr_reg      <= '0;
            issued_reg    <= '0;
            received_reg  <= '0;
            read_n_reg    <= 1'b1;
            write_n_reg   <= 1'b1;
            err_reg       <= 1'b0;
            writedata_reg <= '0;
            acc_reg       <= '0;
            i_reg         <= '0;
            n_reg         <= '0;
            k_reg         <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    err_reg     <= 1'b0;
                    read_n_reg  <= 1'b1;
                    write_n_reg <= 1'b1;
                    if (start) begin
                        err_reg       <= cfg_bad;
                        in_cnt_reg    <= in_count;
                        out_cnt_reg   <= out_count;
                        wgt_total_reg <= 32'(in_count) * 32'(out_count);
                        wgt_base_reg  <= wgt_base;
                        bias_base_reg <= bias_base;
                        res_base_reg  <= res_base;
                        addr_reg      <= act_base;
                        issued_reg    <= '0;
                        received_reg  <= '0;
                        acc_reg       <= '0;
                        i_reg         <= '0;
                        n_reg         <= '0;
                        k_reg         <= '0;
                    end
                end
                S_LOAD_ACT, S_WEIGHTS, S_BIAS: begin
                    issued_reg   <= issued_next;
                    received_reg <= received_next;
                    read_n_reg   <= ~req_next;
                    if (accept)
                        addr_reg <= addr_reg + ADDR_W'(1);
                    // The final weight of a node is folded in the same cycle the sum is stored.
                    if (rvalid && state_reg == S_WEIGHTS) begin
                        if (i_last) begin
                            acc_reg <= '0;
                            i_reg   <= '0;
                            n_reg   <= n_reg + 16'd1;
                        end else begin
                            acc_reg <= acc_sum;
                            i_reg   <= i_reg + 16'd1;
                        end
                    end
                    if (phase_end) begin
                        issued_reg   <= '0;
                        received_reg <= '0;
                        read_n_reg   <= 1'b1;
                        if (state_reg == S_LOAD_ACT)
                            addr_reg <= wgt_base_reg;
                        else if (state_reg == S_WEIGHTS)
                            addr_reg <= bias_base_reg;
                    end
                end
                S_WRITE: begin
                    if (write_n_reg) begin
                        write_n_reg   <= 1'b0;
                        addr_reg      <= res_base_reg + ADDR_W'(k_reg);
                        writedata_reg <= {{(DATA_W-1){1'b0}}, res_mem[k_reg[OIW-1:0]]};
                    end else if (wr_accept) begin
                        if (wr_last) begin
                            write_n_reg <= 1'b1;
                        end else begin
                            k_reg         <= k_inc;
                            addr_reg      <= addr_reg + ADDR_W'(1);
                            writedata_reg <= {{(DATA_W-1){1'b0}}, res_mem[k_inc[OIW-1:0]]};
                        end
                    end
                end
                S_DONE: begin
                    read_n_reg  <= 1'b1;
                    write_n_reg <= 1'b1;
                    if (!start)
                        err_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Buffers carry no reset so they map onto RAM; only the read phases write them.
    always_ff @(posedge clk) begin
        if (rvalid) begin
            case (state_reg)
                S_LOAD_ACT: act_mem[received_reg[AIW-1:0]] <= (readdata != '0);
                S_WEIGHTS:  if (i_last) sum_mem[n_reg[OIW-1:0]] <= acc_sum;
                S_BIAS:     res_mem[received_reg[OIW-1:0]] <= ~bias_sum[ACC_W-1];
                default: ;
            endcase
        end
    end

    assign state      = state_reg;
    assign busy       = in_read || (state_reg == S_WRITE);
    assign done       = (state_reg == S_DONE);
    assign err        = err_reg;
    assign chipselect = in_read || (state_reg == S_WRITE);
    assign address    = addr_reg;
    assign read_n     = read_n_reg;
    assign write_n    = write_n_reg;
    assign writedata  = writedata_reg;
    assign byteenable = '1;

endmodule

// File: doc/bnn_layer_master.md
Name: bnn_layer_master

Overview:
Parametrised Avalon-MM read/write master that evaluates one fully-connected binarised neural-network layer from SDRAM.
- Fetches a 0/1 input activation vector, then node-major weights, then per-node biases.
- Produces a 0/1 output per node: sign of (sum of weights where the input is 1) + bias.
- Writes the outputs back to SDRAM.
- Layer sizes and base addresses are runtime inputs, so one instance serves every hidden and output layer of the classifier.

Parameters:
DATA_W, 16, SDRAM data word width (signed weights/biases/results)
ACC_W, 16, accumulator width; weights/biases sign-extended to ACC_W
MAX_IN, 784, maximum inputs per node (activation buffer depth)
MAX_OUT, 200, maximum nodes per layer (result buffer depth)
ADDR_W, 32, Avalon word-address width
MAX_PEND, 8, maximum outstanding read transactions

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; rising into IDLE begins a layer
in_count  in  16  inputs per node, sampled at start
out_count  in  16  nodes in layer, sampled at start
act_base  in  ADDR_W  word address of input activations
wgt_base  in  ADDR_W  word address of weight[0][0]; weight[n][i] at wgt_base+n*in_count+i
bias_base  in  ADDR_W  word address of bias[0]
res_base  in  ADDR_W  word address for result[0]
busy  out  1  high from start acceptance until DONE entered
done  out  1  high in DONE
err  out  1  config error flag, valid while done
state  out  3  current FSM state (debug)
address  out  ADDR_W  Avalon address (word units)
read_n  out  1  active-low read request
write_n  out  1  active-low write request
chipselect  out  1  Avalon chipselect
byteenable  out  DATA_W/8  always all ones
writedata  out  DATA_W  result word
waitrequest  in  1  slave stall
readdata  in  DATA_W  read response
readdatavalid  in  1  read response strobe

Behaviour:
- Reset values: read_n=1, write_n=1, chipselect=0, address=0, writedata=0, busy=0, done=0, err=0, state=IDLE; all counters and the accumulator are cleared.
- FSM states: IDLE(0), LOAD_ACT(1), WEIGHTS(2), BIAS(3), WRITE(4), DONE(5).
- IDLE, start=1:
  - Latch config, set busy=1.
  - If in_count==0, in_count>MAX_IN, out_count==0 or out_count>MAX_OUT: err=1, go to DONE with no bus traffic.
  - Otherwise go to LOAD_ACT.
- Read issue (LOAD_ACT/WEIGHTS/BIAS):
  - chipselect=1; read_n=0 while issued<total and (issued-received)<MAX_PEND.
  - address/read_n held stable while waitrequest=1.
  - A request is accepted on a clock with read_n=0 and waitrequest=0. On acceptance, issued increments and address advances by 1 on the next cycle.
- Read completion: a phase ends only when received==total, so responses arriving after the last issue are still consumed. Then the FSM moves to the next phase; issued/received clear.
- LOAD_ACT: total=in_count; act[k] = (readdata != 0).
- WEIGHTS: total=in_count*out_count.
  - Each response: if act[i]==1 then acc += sext(readdata), else acc unchanged.
  - At i==in_count-1: store acc into sum[n], clear acc, i=0, n++. Store and clear happen in the same cycle, with the last weight included.
- BIAS: total=out_count. Response k: res[k] = ((sum[k]+sext(readdata)) < 0) ? 0 : 1, evaluated in ACC_W.
- WRITE: write_n=0, address=res_base+k, writedata=zero-extended res[k]. Advance k on waitrequest=0; write_n=1 after the last accepted write.
- DONE: done=1, busy=0, bus idle (chipselect=0). Returns to IDLE when start=0; done and err clear in IDLE.
- start changes during operation are ignored.
- readdatavalid outside read phases is ignored.
- Asynchronous reset mid-operation aborts immediately: bus strobes high, state IDLE, no further writes.
- Accumulation wraps modulo 2^ACC_W.

Optional Feature:
ACC_SAT_EN:
- Defined: accumulator and bias sums saturate at +2^(ACC_W-1)-1 and -2^(ACC_W-1).
- Undefined: two's-complement wrap.
- Sign decisions use the saturated or wrapped value respectively.

Test Plan:
- in_count=4, out_count=2, acts {1,0,1,1}, weights {5,9,-3,1 | -2,7,-1,-4}, biases {-3,8}, zero wait states -> sums 3,-7; results 1,1 written to res_base, res_base+1; done=1, err=0.
- Same data with bias {-4,6} -> results 0,0; exactly 2 writes, then write_n stays 1.
- waitrequest randomly asserted 50% and readdatavalid delayed 1-6 cycles -> identical results; never more than 8 reads outstanding; address stable while stalled.
- out_count=0 or in_count=785 -> err=1, done=1 within 2 cycles, no read_n/write_n assertion.
- Full size 784x200: acts all 1, weights all 1, bias -784 -> all 200 results 1; bias -785 -> all 0.
- reset pulsed during WEIGHTS -> read_n=1, write_n=1 same cycle, state=0; a subsequent start completes correctly.
- ACC_SAT_EN: 4 weights of 16000 with all acts 1 -> sum 32767 (saturated), not wrapped negative; result 1 with bias 0.
